// File: rtl/uart_pkg.sv
// Shared definitions for the UART stream blocks.
//   uart_state_e : transmitter FSM state encoding
//   PAR_*        : parity mode selector values
//   calc_div     : clocks per bit from clock frequency and baud rate
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Integer division: any remainder is dropped, so the real baud rate is
    // slightly above nominal when CLK_HZ is not a multiple of BAUD.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer shared by the UART transmitter (and a future receiver).
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   restart : hold the count at zero (used while the line is idle)
//   tick    : high during the last cycle (count == DIV-1) of a bit period
// The count wraps from DIV-1 to 0 on its own, so each consecutive bit
// period starts at zero without an explicit restart.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int              W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// Valid/ready byte stream to UART serial line: 8 data bits LSB first,
// optional parity, 1 or 2 stop bits. A one-byte holding register lets the
// next byte be accepted while the current frame is on the line, so frames
// follow each other with no idle gap.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   in_valid : in_data holds a byte
//   in_ready : holding register is empty (registered, no path from in_valid)
//   in_data  : byte to transmit
//   tx       : serial line, idle high (registered)
//   busy     : frame in flight or holding register full
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tx,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    uart_state_e state_q, state_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        tick;
    logic        par_bit;

    uart_baud_counter #(
        .DIV (DIV)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state_q == ST_IDLE),
        .tick    (tick)
    );

    assign par_bit = (PARITY == PAR_ODD) ? ~^data_q : ^data_q;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        data_d      = data_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;

        // Accept only into an empty holding register; a load out of the
        // register below can never coincide with an accept.
        if (in_valid && !hold_full_q) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    data_d      = hold_data_q;
                    hold_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = ST_START;
                    tx_d        = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = data_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = data_q[bit_cnt_q + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when a byte
                        // is already waiting.
                        if (hold_full_q) begin
                            data_d      = hold_data_q;
                            hold_full_d = 1'b0;
                            bit_cnt_d   = '0;
                            state_d     = ST_START;
                            tx_d        = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            data_q      <= '0;
            bit_cnt_q   <= '0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            data_q      <= data_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
        end
    end

    assign in_ready = !hold_full_q;
    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Self-checking bench for uart_tx_stream. Four instances cover the parity and
// stop-bit variants at DIV=4; each stream is compared cycle by cycle against
// a frame image built from the line format (start, 8 data LSB first, parity,
// stop bits, each bit DIV clocks long).
module tb_uart_tx_stream;

    localparam int CLK_HZ = 400;
    localparam int BAUD   = 100;
    localparam int DIV    = 4;

    logic       clk;
    logic       rst_n;
    logic       in_valid [4];
    logic [7:0] in_data  [4];
    logic       rdy_w    [4];
    logic       tx_w     [4];
    logic       busy_w   [4];

    int         par_of [4];
    int         sb_of  [4];
    logic [7:0] stim   [4];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_stream #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy_w[0]),
        .in_data(in_data[0]), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_stream #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy_w[1]),
        .in_data(in_data[1]), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_stream #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy_w[2]),
        .in_data(in_data[2]), .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx_stream #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(rdy_w[3]),
        .in_data(in_data[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Append the line image of one frame (each bit repeated DIV times).
    task automatic add_frame(inout bit q[$], input logic [7:0] b, input int par, input int sb);
        bit fb[$];
        int ones;
        ones = $countones(b);
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(b[i]);
        if (par == 1) fb.push_back((ones % 2) == 0);   // odd: total ones odd
        if (par == 2) fb.push_back((ones % 2) == 1);   // even: total ones even
        for (int i = 0; i < sb; i++) fb.push_back(1'b1);
        foreach (fb[m]) for (int r = 0; r < DIV; r++) q.push_back(fb[m]);
    endtask

    // Present stim[0..n-1] continuously on instance idx and check the line,
    // busy and the edge on which each byte is accepted.
    task automatic run_stream(input int idx, input int n);
        bit exp_q[$];
        int total;
        int flen;
        int sent;
        int exp_edge;
        bit pend;
        for (int j = 0; j < n; j++) add_frame(exp_q, stim[j], par_of[idx], sb_of[idx]);
        total = exp_q.size();
        flen  = total / n;
        $display("stream dut%0d: %0d byte(s) first=%02h frame=%0d clocks", idx, n, stim[0], flen);
        @(negedge clk);
        in_valid[idx] = 1'b1;
        in_data[idx]  = stim[0];
        sent = 0;
        chk("ready_when_idle", int'(rdy_w[idx]), 1);
        pend = rdy_w[idx];
        for (int c = 0; c <= total + 1; c++) begin
            @(negedge clk);   // now just after edge number c (c=0: first accept edge)
            if (pend) begin
                // byte0 on edge 0, byte1 right after byte0 leaves the holding
                // register, later bytes right after each previous frame ends
                exp_edge = (sent == 0) ? 0 : (sent == 1) ? 2 : 2 + (sent - 1) * flen;
                chk("accept_edge", c, exp_edge);
                sent++;
                if (sent < n) in_data[idx] = stim[sent];
                else          in_valid[idx] = 1'b0;
            end
            pend = in_valid[idx] && rdy_w[idx];
            if (c == 0)              chk("tx_before_start", int'(tx_w[idx]), 1);
            else if (c - 1 < total)  chk("tx_frame", int'(tx_w[idx]), int'(exp_q[c-1]));
            else                     chk("tx_idle_after", int'(tx_w[idx]), 1);
            chk("busy", int'(busy_w[idx]), (c <= total) ? 1 : 0);
        end
        chk("bytes_accepted", sent, n);
        in_valid[idx] = 1'b0;
    endtask

    initial begin
        bit rq[$];
        logic [7:0] rb;
        int n;
        n_cmp = 0;
        n_bad = 0;
        par_of = '{0, 2, 1, 0};
        sb_of  = '{1, 1, 1, 2};

        // Reset held with in_valid high: nothing may be accepted.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 8'hA5;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_tx", int'(tx_w[i]), 1);
            chk("reset_busy", int'(busy_w[i]), 0);
            chk("reset_ready", int'(rdy_w[i]), 1);
        end
        for (int i = 0; i < 4; i++) in_valid[i] = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("post_reset_tx", int'(tx_w[i]), 1);
            chk("post_reset_busy", int'(busy_w[i]), 0);
        end
        $display("reset checks done");

        // Directed cases.
        stim[0] = 8'hA5;
        run_stream(0, 1);
        stim[0] = 8'h00; stim[1] = 8'hFF; stim[2] = 8'h3C;
        run_stream(0, 3);
        stim[0] = 8'h07;
        run_stream(1, 1);
        run_stream(2, 1);
        stim[0] = 8'h55; stim[1] = 8'($urandom);
        run_stream(3, 2);

        // Randomized streams on every configuration.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) stim[j] = 8'($urandom);
                run_stream(i, n);
            end
        end

        // Reset during data bit 3 (line samples 16..19 of the frame image).
        rb = 8'($urandom);
        rb[3] = 1'b0;
        add_frame(rq, rb, 0, 1);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = rb;
        @(negedge clk);
        in_valid[0] = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            chk("midreset_pre_tx", int'(tx_w[0]), int'(rq[c-1]));
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_async_tx", int'(tx_w[0]), 1);
        chk("midreset_busy", int'(busy_w[0]), 0);
        chk("midreset_ready", int'(rdy_w[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk("midreset_after_tx", int'(tx_w[0]), 1);
            chk("midreset_after_busy", int'(busy_w[0]), 0);
        end
        chk("midreset_after_ready", int'(rdy_w[0]), 1);
        $display("mid-frame reset on byte %02h done", rb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
